// File: rtl/gx4000_asic_pkg.sv
// Shared types for the Plus ASIC RAM arbiter slice.
// Address width, requester owner tags, round-robin state.
package gx4000_asic_pkg;

  localparam int ASIC_RAM_AW = 14;

  // CPU is forced ahead of sprites after this many denied cycles
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_SPR,
    REQ_DMA,
    REQ_CPU
  } req_owner_t;

  typedef enum logic {
    RR_DMA,
    RR_CPU
  } rr_t;

endpackage

// File: rtl/gx4000_asic_ram_arb_if.sv
// Requester and RAM-command bus of the ASIC RAM arbiter.
// master: requesters + RAM storage side; slave: the arbiter.
interface gx4000_asic_ram_arb_if;
  import gx4000_asic_pkg::*;

  logic                   spr_req;
  logic [ASIC_RAM_AW-1:0] spr_addr;
  logic                   spr_gnt;
  logic                   spr_rvalid;
  logic [7:0]             spr_rdata;

  logic                   dma_req;
  logic [ASIC_RAM_AW-1:0] dma_addr;
  logic                   dma_gnt;
  logic                   dma_rvalid;
  logic [7:0]             dma_rdata;

  logic                   cpu_req;
  logic                   cpu_we;
  logic [ASIC_RAM_AW-1:0] cpu_addr;
  logic [7:0]             cpu_wdata;
  logic                   cpu_gnt;
  logic                   cpu_rvalid;
  logic [7:0]             cpu_rdata;
  logic                   cpu_wait;

  logic [ASIC_RAM_AW-1:0] ram_addr;
  logic                   ram_rd;
  logic                   ram_wr;
  logic [7:0]             ram_din;
  logic [7:0]             ram_q;

  modport master (
    output spr_req, spr_addr,
    input  spr_gnt, spr_rvalid, spr_rdata,
    output dma_req, dma_addr,
    input  dma_gnt, dma_rvalid, dma_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_wait,
    input  ram_addr, ram_rd, ram_wr, ram_din,
    output ram_q
  );

  modport slave (
    input  spr_req, spr_addr,
    output spr_gnt, spr_rvalid, spr_rdata,
    input  dma_req, dma_addr,
    output dma_gnt, dma_rvalid, dma_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_wait,
    output ram_addr, ram_rd, ram_wr, ram_din,
    input  ram_q
  );

endinterface

// File: rtl/gx4000_asic_rdpipe.sv
// Two-stage owner-tag pipeline and read-data demux.
// Ports: clk_i, rst_i, tag_i (issue tag), q_i (RAM data), per-requester rvalid/rdata.
module gx4000_asic_rdpipe
  import gx4000_asic_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  req_owner_t tag_i,
  input  logic [7:0] q_i,
  output logic       spr_rvalid_o,
  output logic [7:0] spr_rdata_o,
  output logic       dma_rvalid_o,
  output logic [7:0] dma_rdata_o,
  output logic       cpu_rvalid_o,
  output logic [7:0] cpu_rdata_o
);

  req_owner_t tag1_q;
  req_owner_t tag2_q;
  logic [7:0] spr_hold_q;
  logic [7:0] dma_hold_q;
  logic [7:0] cpu_hold_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag1_q     <= REQ_NONE;
      tag2_q     <= REQ_NONE;
      spr_hold_q <= '0;
      dma_hold_q <= '0;
      cpu_hold_q <= '0;
    end else begin
      tag1_q <= tag_i;
      tag2_q <= tag1_q;
      if (spr_rvalid_o) spr_hold_q <= q_i;
      if (dma_rvalid_o) dma_hold_q <= q_i;
      if (cpu_rvalid_o) cpu_hold_q <= q_i;
    end
  end

  assign spr_rvalid_o = (tag2_q == REQ_SPR);
  assign dma_rvalid_o = (tag2_q == REQ_DMA);
  assign cpu_rvalid_o = (tag2_q == REQ_CPU);

  // RAM data lands in the rvalid cycle; the hold regs keep it afterwards
  assign spr_rdata_o = spr_rvalid_o ? q_i : spr_hold_q;
  assign dma_rdata_o = dma_rvalid_o ? q_i : dma_hold_q;
  assign cpu_rdata_o = cpu_rvalid_o ? q_i : cpu_hold_q;

endmodule

// File: rtl/gx4000_asic_ram_arb.sv
// Plus ASIC RAM arbiter: sprite > DMA/CPU round-robin, registered RAM command.
// Ports: clk_sys, reset, plus_mode, bus (slave). Option macro: GX4000_ARB_STARVE_EN.
module gx4000_asic_ram_arb
  import gx4000_asic_pkg::*;
(
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 plus_mode,
  gx4000_asic_ram_arb_if.slave bus
);

  logic gnt_spr;
  logic gnt_dma;
  logic gnt_cpu;
  logic starve_ovr;

  rr_t                    rr_q;
  rr_t                    rr_d;
  logic [ASIC_RAM_AW-1:0] addr_q;
  logic [ASIC_RAM_AW-1:0] addr_d;
  logic                   rd_q;
  logic                   wr_q;
  logic [7:0]             din_q;
  logic [7:0]             din_d;
  req_owner_t             tag;

`ifdef GX4000_ARB_STARVE_EN
  logic [2:0] starve_q;
  logic [2:0] starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!bus.cpu_req || gnt_cpu)
      starve_d = '0;
    else if (starve_q != 3'(STARVE_LIMIT))
      starve_d = starve_q + 3'd1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign starve_ovr = (starve_q == 3'(STARVE_LIMIT));
`else
  assign starve_ovr = 1'b0;
`endif

  // Grants are gated by reset so they drop with it asynchronously
  always_comb begin
    gnt_spr = 1'b0;
    gnt_dma = 1'b0;
    gnt_cpu = 1'b0;
    if (plus_mode && !reset) begin
      if (starve_ovr && bus.cpu_req)
        gnt_cpu = 1'b1;
      else if (bus.spr_req)
        gnt_spr = 1'b1;
      else if (bus.dma_req && bus.cpu_req) begin
        if (rr_q == RR_DMA) gnt_cpu = 1'b1;
        else                gnt_dma = 1'b1;
      end else if (bus.dma_req)
        gnt_dma = 1'b1;
      else if (bus.cpu_req)
        gnt_cpu = 1'b1;
    end
  end

  // Writes carry no tag: they never return data
  always_comb begin
    tag    = REQ_NONE;
    addr_d = addr_q;
    din_d  = din_q;
    rr_d   = rr_q;
    unique case (1'b1)
      gnt_spr: begin
        tag    = REQ_SPR;
        addr_d = bus.spr_addr;
      end
      gnt_dma: begin
        tag    = REQ_DMA;
        addr_d = bus.dma_addr;
        rr_d   = RR_DMA;
      end
      gnt_cpu: begin
        tag    = bus.cpu_we ? REQ_NONE : REQ_CPU;
        addr_d = bus.cpu_addr;
        rr_d   = RR_CPU;
        if (bus.cpu_we) din_d = bus.cpu_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      din_q  <= '0;
      rr_q   <= RR_DMA;
    end else begin
      addr_q <= addr_d;
      rd_q   <= gnt_spr | gnt_dma | (gnt_cpu & ~bus.cpu_we);
      wr_q   <= gnt_cpu & bus.cpu_we;
      din_q  <= din_d;
      rr_q   <= rr_d;
    end
  end

  gx4000_asic_rdpipe u_rdpipe (
    .clk_i        (clk_sys),
    .rst_i        (reset),
    .tag_i        (tag),
    .q_i          (bus.ram_q),
    .spr_rvalid_o (bus.spr_rvalid),
    .spr_rdata_o  (bus.spr_rdata),
    .dma_rvalid_o (bus.dma_rvalid),
    .dma_rdata_o  (bus.dma_rdata),
    .cpu_rvalid_o (bus.cpu_rvalid),
    .cpu_rdata_o  (bus.cpu_rdata)
  );

  assign bus.spr_gnt  = gnt_spr;
  assign bus.dma_gnt  = gnt_dma;
  assign bus.cpu_gnt  = gnt_cpu;
  assign bus.cpu_wait = bus.cpu_req & ~gnt_cpu;
  assign bus.ram_addr = addr_q;
  assign bus.ram_rd   = rd_q;
  assign bus.ram_wr   = wr_q;
  assign bus.ram_din  = din_q;

endmodule
